// File: rtl/chord_sched_pkg.sv
// rtl/chord_sched_pkg.sv - shared types and constants for the chord scheduler
// Contents: FSM state enum, song entry field positions, default voice capacity.
package chord_sched_pkg;

    localparam int NUM_VOICES_DEF = 3;

    // Song entry layout: {wait[12], note[11:6], duration[5:0]}
    localparam int ENTRY_W  = 13;
    localparam int WAIT_BIT = 12;
    localparam int NOTE_HI  = 11;
    localparam int NOTE_LO  = 6;
    localparam int DUR_HI   = 5;
    localparam int DUR_LO   = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_ISSUE,
        ST_WAIT_VOICE,
        ST_WAIT_BEATS,
        ST_DONE
    } state_e;

endpackage

// File: rtl/voice_counter.sv
// rtl/voice_counter.sv - saturating occupancy counter for sounding voices
// Ports: clk, reset_n (async active-low), inc (voice loaded), dec (voice finished),
//        count (voices currently sounding, 0..MAX).
module voice_counter
    import chord_sched_pkg::*;
#(
    parameter int MAX = NUM_VOICES_DEF,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] MAX_C = W'(MAX);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Coincident inc/dec cancel; dec at empty and inc at full are dropped.
    always_comb begin
        count_d = count_q;
        if (inc && !dec && (count_q < MAX_C)) begin
            count_d = count_q + W'(1);
        end else if (dec && !inc && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/chord_scheduler.sv
// rtl/chord_scheduler.sv - walks a song memory and feeds note loads to the chords engine
// Ports: clk, reset_n (async active-low), start, play, beat, note_done (inputs);
//        rom_addr / rom_data (song memory, 1-cycle read latency);
//        play_enable, load_new_note, note_to_load, duration, busy, song_done (outputs).
module chord_scheduler
    import chord_sched_pkg::*;
#(
    parameter int ADDR_W     = 7,
    parameter int NUM_VOICES = NUM_VOICES_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               play,
    input  logic               beat,
    input  logic               note_done,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [ENTRY_W-1:0] rom_data,
    output logic               play_enable,
    output logic               load_new_note,
    output logic [5:0]         note_to_load,
    output logic [5:0]         duration,
    output logic               busy,
    output logic               song_done
);

    localparam int             CNT_W  = $clog2(NUM_VOICES + 1);
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(NUM_VOICES);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [5:0]        beat_cnt_q, beat_cnt_d;
    logic [5:0]        ent_note_q, ent_note_d;
    logic [5:0]        ent_dur_q, ent_dur_d;
    logic [5:0]        note_q, note_d;
    logic [5:0]        dur_q, dur_d;
    logic [CNT_W-1:0]  active_voices;

    logic       ent_wait;
    logic [5:0] ent_note;
    logic [5:0] ent_dur;
    logic       issue_fire;
    logic       voice_free;
    logic       advance;

    assign ent_wait   = rom_data[WAIT_BIT];
    assign ent_note   = rom_data[NOTE_HI:NOTE_LO];
    assign ent_dur    = rom_data[DUR_HI:DUR_LO];
    assign issue_fire = (state_q == ST_ISSUE) && play;
    assign voice_free = active_voices < MAX_C;

    always_comb begin
        state_d    = state_q;
        rom_addr_d = rom_addr_q;
        beat_cnt_d = beat_cnt_q;
        ent_note_d = ent_note_q;
        ent_dur_d  = ent_dur_q;
        note_d     = note_q;
        dur_d      = dur_q;
        advance    = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    rom_addr_d = '0;
                    state_d    = ST_FETCH;
                end
            end
            ST_FETCH: state_d = ST_DECODE;
            ST_DECODE: begin
                ent_note_d = ent_note;
                ent_dur_d  = ent_dur;
                if (rom_data == '0) begin
                    state_d = ST_DONE;
                end else if (ent_wait) begin
                    if (ent_dur != '0) begin
                        beat_cnt_d = ent_dur;
                        state_d    = ST_WAIT_BEATS;
                    end else begin
                        advance = 1'b1;
                    end
                end else if ((ent_note == '0) || (ent_dur == '0)) begin
                    advance = 1'b1;
                end else begin
                    state_d = voice_free ? ST_ISSUE : ST_WAIT_VOICE;
                end
            end
            ST_ISSUE: begin
                if (play) begin
                    note_d  = ent_note_q;
                    dur_d   = ent_dur_q;
                    advance = 1'b1;
                end
            end
            ST_WAIT_VOICE: begin
                if (voice_free) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_WAIT_BEATS: begin
                if (beat_cnt_q == '0) begin
                    advance = 1'b1;
                end else if (beat && play) begin
                    beat_cnt_d = beat_cnt_q - 6'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // The song ends at the top of memory rather than wrapping to 0.
        if (advance) begin
            if (rom_addr_q == '1) begin
                state_d = ST_DONE;
            end else begin
                rom_addr_d = rom_addr_q + ADDR_W'(1);
                state_d    = ST_FETCH;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            rom_addr_q <= '0;
            beat_cnt_q <= '0;
            ent_note_q <= '0;
            ent_dur_q  <= '0;
            note_q     <= '0;
            dur_q      <= '0;
        end else begin
            state_q    <= state_d;
            rom_addr_q <= rom_addr_d;
            beat_cnt_q <= beat_cnt_d;
            ent_note_q <= ent_note_d;
            ent_dur_q  <= ent_dur_d;
            note_q     <= note_d;
            dur_q      <= dur_d;
        end
    end

    voice_counter #(
        .MAX (NUM_VOICES),
        .W   (CNT_W)
    ) u_voice_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (issue_fire),
        .dec     (note_done),
        .count   (active_voices)
    );

    // The load fires inside the ISSUE cycle so a freed voice is refilled one
    // cycle after the FSM sees it; note/duration show the entry during that
    // cycle and hold the last loaded values otherwise.
    assign rom_addr      = rom_addr_q;
    assign load_new_note = issue_fire;
    assign note_to_load  = issue_fire ? ent_note_q : note_q;
    assign duration      = issue_fire ? ent_dur_q : dur_q;
    assign busy          = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign song_done     = (state_q == ST_DONE);
    assign play_enable   = busy && play;

endmodule

// File: tb/tb_chord_scheduler.sv
// tb/tb_chord_scheduler.sv - self-checking bench for chord_scheduler
module tb_chord_scheduler;

    localparam int AW = 7;
    localparam int NV = 3;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          play = 1'b0;
    logic          beat = 1'b0;
    logic          note_done = 1'b0;
    logic [AW-1:0] rom_addr;
    logic [12:0]   rom_data = '0;
    logic          play_enable;
    logic          load_new_note;
    logic [5:0]    note_to_load;
    logic [5:0]    duration;
    logic          busy;
    logic          song_done;

    chord_scheduler #(.ADDR_W(AW), .NUM_VOICES(NV)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .play          (play),
        .beat          (beat),
        .note_done     (note_done),
        .rom_addr      (rom_addr),
        .rom_data      (rom_data),
        .play_enable   (play_enable),
        .load_new_note (load_new_note),
        .note_to_load  (note_to_load),
        .duration      (duration),
        .busy          (busy),
        .song_done     (song_done)
    );

    always #5 clk = ~clk;

    logic [12:0] rom [0:(1<<AW)-1];
    always @(posedge clk) rom_data <= rom[rom_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int note;
        int dur;
        int at;
    } exp_t;

    exp_t exp_q[$];
    int   model_cnt = 0;
    int   last_load = -100;
    int   last_note = 0;
    int   last_dur = 0;
    int   loads_seen = 0;

    // Reference model: expected loads in order, voice occupancy from load and
    // note_done events, held note/duration between loads.
    always @(negedge clk) begin
        if (!reset_n) begin
            model_cnt = 0;
            last_load = -100;
            last_note = 0;
            last_dur  = 0;
        end else begin
            chk("active_voices", int'(dut.active_voices), model_cnt);
            chk("play_enable", int'(play_enable), int'(play && busy));
            chk("busy_xor_done", int'(busy && song_done), 0);
            if (load_new_note) begin
                loads_seen++;
                chk("load_spacing", int'(cyc - last_load >= 3), 1);
                chk("load_voice_free", int'(model_cnt < NV), 1);
                last_load = cyc;
                if (exp_q.size() == 0) begin
                    chk("unexpected_load", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("load_note", int'(note_to_load), e.note);
                    chk("load_dur", int'(duration), e.dur);
                    if (e.at >= 0) chk("load_cycle", cyc, e.at);
                    last_note = e.note;
                    last_dur  = e.dur;
                end
            end else begin
                chk("note_held", int'(note_to_load), last_note);
                chk("dur_held", int'(duration), last_dur);
            end
            if (load_new_note && !note_done && model_cnt < NV) model_cnt++;
            else if (note_done && !load_new_note && model_cnt > 0) model_cnt--;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [12:0] ent(input int w, input int n, input int d);
        return 13'((w << 12) | (n << 6) | d);
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < (1 << AW); i++) rom[i] = '0;
    endtask

    // Starts a song; returns the cycle during which start was high.
    task automatic do_start(output int s0);
        start = 1'b1;
        s0 = cyc;
        tick(1);
        start = 1'b0;
    endtask

    task automatic pulse_beat();
        beat = 1'b1;
        tick(1);
        beat = 1'b0;
        tick(1);
    endtask

    task automatic clear_voices();
        for (int i = 0; i < NV; i++) begin
            if (model_cnt > 0) begin
                note_done = 1'b1;
                tick(1);
                note_done = 1'b0;
                tick(1);
            end
        end
    endtask

    task automatic wait_done(input int limit, input string name);
        int n = 0;
        while (!song_done && n < limit) begin
            tick(1);
            n++;
        end
        chk(name, int'(song_done), 1);
    endtask

    int s0;
    int t;
    int loads_before;

    initial begin
        clear_rom();
        tick(3);
        chk("reset_rom_addr", int'(rom_addr), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(song_done), 0);
        chk("reset_load", int'(load_new_note), 0);
        reset_n = 1'b1;
        play = 1'b1;
        tick(2);

        // Single load followed by a 4-beat wait, then end marker.
        rom[0] = ent(0, 28, 1);
        rom[1] = ent(1, 0, 4);
        do_start(s0);
        exp_q.push_back('{28, 1, s0 + 3});
        tick(5);
        repeat (3) pulse_beat();
        chk("t1_not_done_3beats", int'(song_done), 0);
        chk("t1_addr_waiting", int'(rom_addr), 1);
        pulse_beat();
        wait_done(10, "t1_done");
        chk("t1_final_addr", int'(rom_addr), 2);
        chk("t1_busy_low", int'(busy), 0);
        chk("t1_all_loads", exp_q.size(), 0);

        // Four-note chord against three voices: fourth load waits for a voice.
        clear_voices();
        clear_rom();
        rom[0] = ent(0, 20, 16);
        rom[1] = ent(0, 24, 16);
        rom[2] = ent(0, 27, 16);
        rom[3] = ent(0, 32, 10);
        do_start(s0);
        exp_q.push_back('{20, 16, s0 + 3});
        exp_q.push_back('{24, 16, s0 + 6});
        exp_q.push_back('{27, 16, s0 + 9});
        tick(20);
        chk("t2_stalled_busy", int'(busy), 1);
        chk("t2_stalled_addr", int'(rom_addr), 3);
        chk("t2_three_loads", exp_q.size(), 0);
        note_done = 1'b1;
        t = cyc;
        exp_q.push_back('{32, 10, t + 2});
        tick(1);
        note_done = 1'b0;
        wait_done(20, "t2_done");
        chk("t2_final_addr", int'(rom_addr), 4);
        chk("t2_voices_persist", int'(dut.active_voices), 3);
        chk("t2_all_loads", exp_q.size(), 0);

        // Zero-note entry is skipped.
        clear_voices();
        clear_rom();
        rom[0] = ent(0, 0, 8);
        rom[1] = ent(0, 25, 20);
        do_start(s0);
        exp_q.push_back('{25, 20, s0 + 5});
        wait_done(20, "t3_done");
        chk("t3_final_addr", int'(rom_addr), 2);
        chk("t3_all_loads", exp_q.size(), 0);

        // Paused beats are ignored.
        clear_voices();
        clear_rom();
        rom[0] = ent(1, 0, 6);
        do_start(s0);
        tick(2);
        repeat (2) pulse_beat();
        play = 1'b0;
        repeat (5) pulse_beat();
        chk("t4_paused_busy", int'(busy), 1);
        chk("t4_paused_enable", int'(play_enable), 0);
        chk("t4_paused_addr", int'(rom_addr), 0);
        play = 1'b1;
        repeat (3) pulse_beat();
        tick(2);
        chk("t4_not_adv_3beats", int'(rom_addr), 0);
        chk("t4_not_done_3beats", int'(song_done), 0);
        pulse_beat();
        wait_done(10, "t4_done");
        chk("t4_final_addr", int'(rom_addr), 1);

        // Reset in the middle of a wait after a 3-voice chord.
        clear_voices();
        clear_rom();
        rom[0] = ent(0, 20, 16);
        rom[1] = ent(0, 24, 16);
        rom[2] = ent(0, 27, 16);
        rom[3] = ent(1, 0, 10);
        do_start(s0);
        exp_q.push_back('{20, 16, s0 + 3});
        exp_q.push_back('{24, 16, s0 + 6});
        exp_q.push_back('{27, 16, s0 + 9});
        tick(14);
        chk("t5_pre_busy", int'(busy), 1);
        chk("t5_pre_loads", exp_q.size(), 0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t5_rst_addr", int'(rom_addr), 0);
        chk("t5_rst_busy", int'(busy), 0);
        chk("t5_rst_enable", int'(play_enable), 0);
        chk("t5_rst_load", int'(load_new_note), 0);
        chk("t5_rst_note", int'(note_to_load), 0);
        chk("t5_rst_dur", int'(duration), 0);
        chk("t5_rst_done", int'(song_done), 0);
        chk("t5_rst_voices", int'(dut.active_voices), 0);
        tick(2);
        reset_n = 1'b1;
        loads_before = loads_seen;
        for (int i = 0; i < 500; i++) begin
            beat = (i % 4 == 0);
            tick(1);
        end
        beat = 1'b0;
        chk("t5_no_load_500", loads_seen - loads_before, 0);
        chk("t5_idle_busy", int'(busy), 0);

        // note_done coincident with a load at two active voices.
        clear_rom();
        rom[0] = ent(0, 10, 5);
        rom[1] = ent(0, 11, 5);
        rom[2] = ent(0, 12, 5);
        do_start(s0);
        exp_q.push_back('{10, 5, s0 + 3});
        exp_q.push_back('{11, 5, s0 + 6});
        exp_q.push_back('{12, 5, s0 + 9});
        tick(8);
        note_done = 1'b1;
        tick(1);
        note_done = 1'b0;
        chk("t6_coincident_cnt", int'(dut.active_voices), 2);
        wait_done(20, "t6_done");
        chk("t6_final_cnt", int'(dut.active_voices), 2);

        // Top-of-memory entry ends the song without wrapping; start while busy ignored.
        clear_voices();
        for (int i = 0; i < (1 << AW) - 1; i++) rom[i] = ent(0, 0, 1);
        rom[(1 << AW) - 1] = ent(0, 33, 2);
        do_start(s0);
        exp_q.push_back('{33, 2, s0 + 257});
        tick(50);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_done(400, "t7_done");
        chk("t7_final_addr", int'(rom_addr), (1 << AW) - 1);
        chk("t7_all_loads", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
